// File: rtl/fixed_to_float_seq_if.sv
// ---------------------------------------------------------------------------
// fixed_to_float_seq_if : Nios multi-cycle handshake bundle for the packer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fixed_to_float_seq_if #(
  parameter int WIDTH = 21
);
  logic             clk_en;
  logic             start;
  logic [WIDTH-1:0] fixed_in;
  logic             done;
  logic             busy;
  logic [31:0]      result;

  modport master (
    output clk_en, start, fixed_in,
    input  done, busy, result
  );

  modport slave (
    input  clk_en, start, fixed_in,
    output done, busy, result
  );
endinterface

`default_nettype wire

// File: rtl/fixed_to_float_seq.sv
// ---------------------------------------------------------------------------
// fixed_to_float_seq : iterative normaliser, unsigned Q1.20 -> IEEE-754 single
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fixed_to_float_seq #(
  parameter int WIDTH       = 21,
  parameter int FRAC_BITS   = 20,
  parameter int EXP_BIAS    = 127,
  parameter int COARSE_STEP = 4
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  fixed_to_float_seq_if.slave bus
);

  localparam int         MANT_PAD = 23 - FRAC_BITS;
  localparam logic [7:0] BIAS8    = 8'(EXP_BIAS);
  localparam logic [4:0] STEP5    = 5'(COARSE_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       k_q, k_d;
  logic [31:0]      result_q, result_d;
  logic [7:0]       w_exp;

  // k never exceeds FRAC_BITS, so the 8-bit exponent cannot wrap.
  assign w_exp = BIAS8 - {3'b000, k_q};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    k_d      = k_q;
    result_d = result_q;
    if (bus.clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            shreg_d = bus.fixed_in;
            k_d     = 5'd0;
            state_d = S_NORM;
          end
        end
        S_NORM: begin
          if (shreg_q == '0) begin
            result_d = 32'h0000_0000;
            state_d  = S_DONE;
          end else if (shreg_q[WIDTH-1]) begin
            result_d = {1'b0, w_exp, shreg_q[FRAC_BITS-1:0], {MANT_PAD{1'b0}}};
            state_d  = S_DONE;
          end else if (shreg_q[WIDTH-1 -: COARSE_STEP] == '0) begin
            shreg_d = shreg_q << COARSE_STEP;
            k_d     = k_q + STEP5;
          end else begin
            shreg_d = shreg_q << 1;
            k_d     = k_q + 5'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      k_q      <= 5'd0;
      result_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  // Status decodes straight from the state register, so a stall freezes them too.
  assign bus.done   = (state_q == S_DONE);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.result = result_q;

endmodule

`default_nettype wire
